timer_request_scheduler: RTL and testbench

- Shares the single Avalon interval timer (16-bit register map, one-shot capable) among N_REQ hardware requesters, each asking for a one-shot delay of a given cycle count.
- Round-robin arbitration picks one requester at a time.
- An Avalon-MM master FSM then programs the period, starts the timer, waits for irq, clears the status register and pulses done to the winner.
- Sits between requester blocks and the timer slave port; it is the timer's only master.

---
 rtl/timer_request_scheduler_pkg.sv | 34 +++
 rtl/timer_request_scheduler_if.sv | 46 ++++
 rtl/timer_request_scheduler_rr_arbiter.sv | 34 +++
 rtl/timer_request_scheduler.sv | 146 ++++++++++++++
 tb/tb_timer_request_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_request_scheduler_pkg.sv
// Shared register map, control words, FSM encoding and load helper for the
// timer request scheduler (Avalon interval timer, 16-bit register map).
package timer_sched_pkg;

    localparam logic [2:0]  STATUS  = 3'd0;
    localparam logic [2:0]  CONTROL = 3'd1;
    localparam logic [2:0]  PERIODL = 3'd2;
    localparam logic [2:0]  PERIODH = 3'd3;

    localparam logic [15:0] CTRL_START_ITO = 16'h0005;
    localparam logic [15:0] CTRL_STOP_ITO  = 16'h0009;

    localparam logic [31:0] MIN_PERIOD = 32'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_SETTLE,
        ST_WR_CTRL,
        ST_WAIT,
        ST_STOP,
        ST_CLR,
        ST_DRAIN
    } sched_state_e;

    // Timer counts load+1 cycles, so clamp first to keep the delay >= 2.
    function automatic logic [31:0] period_to_load(input logic [31:0] period);
        logic [31:0] clamped;
        clamped = (period < MIN_PERIOD) ? MIN_PERIOD : period;
        return clamped - 32'd1;
    endfunction

endpackage

// File: rtl/timer_request_scheduler_if.sv
// Requester-side and timer-side signals of the scheduler.
// master: scheduler view; slave: requesters plus the timer slave port.
interface timer_request_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] period;
    logic [N_REQ-1:0]    done;
    logic                busy;
    logic [IDX_W-1:0]    active_idx;

    logic [2:0]          tmr_address;
    logic                tmr_chipselect;
    logic                tmr_write_n;
    logic [15:0]         tmr_writedata;
    logic                tmr_irq;

    modport master (
        input  req,
        input  period,
        input  tmr_irq,
        output done,
        output busy,
        output active_idx,
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata
    );

    modport slave (
        output req,
        output period,
        output tmr_irq,
        input  done,
        input  busy,
        input  active_idx,
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata
    );

endinterface

// File: rtl/timer_request_scheduler_rr_arbiter.sv
// Round-robin pick: first set req bit at or after pointer, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] pointer_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] grant_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Scan from the far end back so the nearest candidate is written last.
    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[wrap_idx(int'(pointer_i), i)]) begin
                valid_o = 1'b1;
                grant_o = wrap_idx(int'(pointer_i), i);
            end
        end
    end

endmodule

// File: rtl/timer_request_scheduler.sv
// Shares one Avalon interval timer among N_REQ one-shot delay requesters.
// done pulses (load+1)+6 cycles after grant; requesters hold req until done.
module timer_request_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input logic                       clk,
    input logic                       reset,
    timer_request_scheduler_if.master bus
);

    sched_state_e     state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      load_hi_q;
    logic [N_REQ-1:0] done_q;
    logic             busy_q;
    logic [2:0]       addr_q;
    logic             cs_q;
    logic             wr_n_q;
    logic [15:0]      wdata_q;

    logic             arb_vld;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] ptr_d;
    logic [31:0]      load_d;
    logic             req_active;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i     (bus.req),
        .pointer_i (ptr_q),
        .valid_o   (arb_vld),
        .grant_o   (arb_idx)
    );

    always_comb begin
        ptr_d      = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        load_d     = period_to_load(bus.period[32*int'(arb_idx) +: 32]);
        req_active = bus.req[idx_q];
    end

    // Bus registers are loaded on the edge that enters a write state, so each
    // write is visible for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            load_hi_q <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            addr_q    <= STATUS;
            cs_q      <= 1'b0;
            wr_n_q    <= 1'b1;
            wdata_q   <= '0;
        end else begin
            cs_q   <= 1'b0;
            wr_n_q <= 1'b1;
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        state_q   <= ST_WR_PL;
                        busy_q    <= 1'b1;
                        idx_q     <= arb_idx;
                        ptr_q     <= ptr_d;
                        load_hi_q <= load_d[31:16];
                        addr_q    <= PERIODL;
                        wdata_q   <= load_d[15:0];
                        cs_q      <= 1'b1;
                        wr_n_q    <= 1'b0;
                    end
                end
                ST_WR_PL: begin
                    state_q <= ST_WR_PH;
                    addr_q  <= PERIODH;
                    wdata_q <= load_hi_q;
                    cs_q    <= 1'b1;
                    wr_n_q  <= 1'b0;
                end
                ST_WR_PH: begin
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state_q <= ST_WR_CTRL;
                    addr_q  <= CONTROL;
                    wdata_q <= CTRL_START_ITO;
                    cs_q    <= 1'b1;
                    wr_n_q  <= 1'b0;
                end
                ST_WR_CTRL: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Expiry beats a simultaneous cancel: no STOP write then.
                    if (bus.tmr_irq) begin
                        state_q <= ST_CLR;
                        addr_q  <= STATUS;
                        wdata_q <= 16'h0000;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                    end else if (!req_active) begin
                        state_q <= ST_STOP;
                        addr_q  <= CONTROL;
                        wdata_q <= CTRL_STOP_ITO;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                    end
                end
                ST_STOP: begin
                    state_q <= ST_CLR;
                    addr_q  <= STATUS;
                    wdata_q <= 16'h0000;
                    cs_q    <= 1'b1;
                    wr_n_q  <= 1'b0;
                end
                ST_CLR: begin
                    state_q <= ST_DRAIN;
                    done_q  <= N_REQ'(1) << idx_q;
                end
                ST_DRAIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done           = done_q;
    assign bus.busy           = busy_q;
    assign bus.active_idx     = idx_q;
    assign bus.tmr_address    = addr_q;
    assign bus.tmr_chipselect = cs_q;
    assign bus.tmr_write_n    = wr_n_q;
    assign bus.tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_request_scheduler.sv
// Bench for timer_request_scheduler: grant vector table with a write scoreboard
// and timer model, plus hand sequences for the irq/cancel race and mid-run reset.
module tb_timer_request_scheduler;
    import timer_sched_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] req;
        logic [31:0]  period;
        int           exp_idx;
        logic [15:0]  exp_pl;
        logic [15:0]  exp_ph;
        int           cancel_at;
        logic [N-1:0] req_after;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_drv = '0;
    logic [32*N-1:0] per_drv = '0;
    logic            irq_q = 1'b0;
    logic            tmr_run = 1'b0;
    logic [31:0]     tmr_cnt = '0;
    logic [15:0]     tmr_pl = '0;
    logic [15:0]     tmr_ph = '0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_done = 0;
    wr_t  exp_wr_q[$];
    wr_t  mon_e;
    vec_t vecs[12];

    timer_request_scheduler_if #(.N_REQ(N)) bus ();

    assign bus.req     = req_drv;
    assign bus.period  = per_drv;
    assign bus.tmr_irq = irq_q;

    timer_request_scheduler #(.N_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timer slave model: irq rises load+1 cycles after the START write.
    always @(posedge clk) begin
        if (bus.tmr_chipselect === 1'b1 && bus.tmr_write_n === 1'b0) begin
            case (bus.tmr_address)
                STATUS:  irq_q <= 1'b0;
                CONTROL: begin
                    if (bus.tmr_writedata[3]) begin
                        tmr_run <= 1'b0;
                    end else if (bus.tmr_writedata[2]) begin
                        tmr_run <= 1'b1;
                        tmr_cnt <= {tmr_ph, tmr_pl};
                    end
                end
                PERIODL: begin tmr_pl <= bus.tmr_writedata; tmr_run <= 1'b0; end
                PERIODH: begin tmr_ph <= bus.tmr_writedata; tmr_run <= 1'b0; end
                default: ;
            endcase
        end else if (tmr_run) begin
            if (tmr_cnt <= 32'd1) begin
                irq_q   <= 1'b1;
                tmr_run <= 1'b0;
            end else begin
                tmr_cnt <= tmr_cnt - 32'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Write scoreboard plus strobe pairing on every cycle.
    always @(negedge clk) begin
        chk("strobe_pair", bus.tmr_chipselect, !bus.tmr_write_n);
        if (bus.tmr_chipselect === 1'b1 && bus.tmr_write_n === 1'b0) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0d data %h at cycle %0d, required none",
                         bus.tmr_address, bus.tmr_writedata, cyc);
            end else begin
                mon_e = exp_wr_q.pop_front();
                chk("tmr_write", {bus.tmr_address, bus.tmr_writedata}, {mon_e.addr, mon_e.data});
            end
        end
    end

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr_q.push_back(w);
    endtask

    task automatic set_periods(input logic [31:0] p);
        for (int l = 0; l < N; l++) per_drv[l*32 +: 32] = p;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},       bus.busy, 0);
        chk({tag, "_done"},       bus.done, 0);
        chk({tag, "_cs"},         bus.tmr_chipselect, 0);
        chk({tag, "_write_n"},    bus.tmr_write_n, 1);
        chk({tag, "_addr"},       bus.tmr_address, 0);
        chk({tag, "_wdata"},      bus.tmr_writedata, 0);
        chk({tag, "_active_idx"}, bus.active_idx, 0);
    endtask

    task automatic wait_done(input string tag, input int idx, input int exp_cyc);
        int           budget;
        logic [N-1:0] one_hot;
        budget = exp_cyc - cyc + 40;
        while (bus.done === '0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        one_hot      = '0;
        one_hot[idx] = 1'b1;
        chk({tag, "_done"},       bus.done, one_hot);
        chk({tag, "_latency"},    cyc, exp_cyc);
        chk({tag, "_active_idx"}, bus.active_idx, idx);
        last_done = cyc;
    endtask

    task automatic grant_cycle(output int g);
        g = (cyc > last_done) ? cyc : last_done + 1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int g;
        int exp_cyc;
        req_drv = v.req;
        set_periods(v.period);
        grant_cycle(g);
        push_wr(PERIODL, v.exp_pl);
        push_wr(PERIODH, v.exp_ph);
        push_wr(CONTROL, CTRL_START_ITO);
        if (v.cancel_at > 0) begin
            push_wr(CONTROL, CTRL_STOP_ITO);
            exp_cyc = g + v.cancel_at + 3;
        end else begin
            exp_cyc = g + int'({v.exp_ph, v.exp_pl}) + 7;
        end
        push_wr(STATUS, 16'h0000);
        // Scramble periods once the grant is taken; the running delay must not move.
        while (cyc < g + 1) @(negedge clk);
        set_periods(32'hFFFF_FFFF);
        if (v.cancel_at > 0) begin
            while (cyc < g + v.cancel_at) @(negedge clk);
            req_drv[v.exp_idx] = 1'b0;
        end
        wait_done(tag, v.exp_idx, exp_cyc);
        req_drv = v.req_after;
        @(negedge clk);
        chk({tag, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g;
        int budget;
        vec_t post;

        vecs[0]  = '{4'b1111, 32'd10,          0, 16'h0009, 16'h0000, 0,  4'b1111};
        vecs[1]  = '{4'b1111, 32'd10,          1, 16'h0009, 16'h0000, 0,  4'b1111};
        vecs[2]  = '{4'b1111, 32'd10,          2, 16'h0009, 16'h0000, 0,  4'b1111};
        vecs[3]  = '{4'b1111, 32'd10,          3, 16'h0009, 16'h0000, 0,  4'b1111};
        vecs[4]  = '{4'b1111, 32'd10,          0, 16'h0009, 16'h0000, 0,  4'b0000};
        vecs[5]  = '{4'b0001, 32'd100,         0, 16'h0063, 16'h0000, 0,  4'b0000};
        vecs[6]  = '{4'b0100, 32'h0001_2345,   2, 16'h2344, 16'h0001, 10, 4'b0000};
        vecs[7]  = '{4'b0010, 32'd0,           1, 16'h0001, 16'h0000, 0,  4'b0000};
        vecs[8]  = '{4'b1000, 32'd1,           3, 16'h0001, 16'h0000, 0,  4'b0000};
        vecs[9]  = '{4'b0110, 32'd20,          1, 16'h0013, 16'h0000, 0,  4'b0110};
        vecs[10] = '{4'b0110, 32'd20,          2, 16'h0013, 16'h0000, 0,  4'b0010};
        vecs[11] = '{4'b0010, 32'd20,          1, 16'h0013, 16'h0000, 0,  4'b0000};

        @(negedge clk);
        check_reset("por");
        @(negedge clk);
        reset     = 1'b0;
        last_done = cyc - 1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // irq and req drop land in the same cycle: irq wins, no STOP write.
        req_drv = 4'b0100;
        set_periods(32'd30);
        grant_cycle(g);
        push_wr(PERIODL, 16'h001D);
        push_wr(PERIODH, 16'h0000);
        push_wr(CONTROL, CTRL_START_ITO);
        push_wr(STATUS,  16'h0000);
        budget = 100;
        while (irq_q !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        req_drv = 4'b0000;
        chk("race_irq_cycle", cyc, g + 29 + 5);
        wait_done("race", 2, g + 29 + 7);
        @(negedge clk);
        chk("race_busy_after", bus.busy, 0);

        // Reset while waiting on the timer; pointer must return to 0.
        req_drv = 4'b0100;
        set_periods(32'd1000);
        grant_cycle(g);
        push_wr(PERIODL, 16'h03E7);
        push_wr(PERIODH, 16'h0000);
        push_wr(CONTROL, CTRL_START_ITO);
        while (cyc < g + 8) @(negedge clk);
        chk("wait_busy", bus.busy, 1);
        chk("wait_idx", bus.active_idx, 2);
        chk("wait_writes_seen", exp_wr_q.size(), 0);
        #1 reset = 1'b1;
        #1 check_reset("mid_rst");
        @(negedge clk);
        reset     = 1'b0;
        last_done = cyc - 1;
        post = '{4'b1010, 32'd5, 1, 16'h0004, 16'h0000, 0, 4'b0000};
        run_vec(post, "post_rst");

        chk("wr_queue_drained", exp_wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
